ifu_fetch: RTL and testbench
============================

# ifu_fetch

Instruction fetch stage directly upstream of the instruction SRAM. Generates the fetch PC and drives the SRAM read port, which has a fixed one-cycle read latency and holds its read data until the next read enable. Captures the returned instruction into a one-entry output register that feeds decode through a valid/ready handshake. Accepts redirects (branch, jump, trap) from later stages.

## Interface
- RESET_PC, 32'h8000_0000: first fetch address after reset; bits [1:0] must be 0.
- clk_i  in  1  clock; all state updates on posedge.
- rst_n_i  in  1  asynchronous, active-low reset.
- redirect_valid_i  in  1  redirect request, one-cycle pulse or held.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (forced 0).
- imem_ren_o  out  1  SRAM read enable.
- imem_addr_o  out  32  SRAM read address (word-aligned).
- imem_rdata_i  in  32  SRAM read data; valid the cycle after a sampled read enable, held while imem_ren_o is low.
- if_valid_o  out  1  instruction valid to decode.
- if_pc_o  out  32  PC of if_inst_o.
- if_inst_o  out  32  fetched instruction.
- id_ready_i  in  1  decode accepts; transfer when if_valid_o && id_ready_i.

## Operation
- State: run_q (1b), pc_q (next fetch PC), inflight_q (1b, read issued last cycle or response still unconsumed in SRAM), inflight_pc_q, out_valid_q/out_pc_q/out_inst_q.
- Reset values: run_q=0, pc_q=RESET_PC, inflight_q=0, inflight_pc_q=0, out_valid_q=0, out_pc_q=0, out_inst_q=0. During reset: imem_ren_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_pc_o=0, if_inst_o=0.
- run_q sets on the first posedge after reset release; imem_ren_o stays 0 while run_q=0.
- fire = out_valid_q && id_ready_i. capture = inflight_q && (!out_valid_q || id_ready_i).
- Normal (no redirect): imem_ren_o = run_q && (!inflight_q || capture); imem_addr_o = pc_q. Issuing a read while an uncaptured response exists is forbidden, because it would overwrite held SRAM data.
- On issue: inflight_pc_q <= pc_q, pc_q <= pc_q + 4 (32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000), inflight_q <= 1.
- On capture: out_inst_q <= imem_rdata_i, out_pc_q <= inflight_pc_q, out_valid_q <= 1. If no new issue occurs in the same cycle, inflight_q <= 0.
- fire without capture: out_valid_q <= 0.
- Redirect (redirect_valid_i=1, run_q=1) has priority over everything:
  - imem_ren_o=1, imem_addr_o={redirect_pc_i[31:2],2'b00}.
  - inflight_pc_q <= that address, pc_q <= address + 4, inflight_q <= 1.
  - out_valid_q <= 0; any pending response is discarded, with no capture.
  - A fire in the redirect cycle still transfers the current if_* values to decode. Decode discards it by its own flush.
- Redirect while run_q=0 is ignored.
- Outputs: if_valid_o=out_valid_q, if_pc_o=out_pc_q, if_inst_o=out_inst_q. These are held stable while if_valid_o && !id_ready_i.

## Timing
- Latency: read issued in cycle N appears on if_* in cycle N+2.
- Throughput: one instruction per cycle while id_ready_i=1.
- First read after reset: imem_ren_o=1 in cycle 1, where cycle 0 is the first posedge with rst_n_i high. First if_valid_o=1 in cycle 3 with if_pc_o=RESET_PC.
- Backpressure: with output full and a response held, imem_ren_o=0 until id_ready_i rises. In the cycle id_ready_i rises, capture and a new issue occur together, with no bubble.
- Redirect: a read of the target is issued in the same cycle. The target instruction is valid two cycles later. if_valid_o=0 in the cycle after the redirect.
- Reset asserted mid-operation: all state returns to reset values asynchronously. Pending responses are lost.

## Test plan
- Reset with RESET_PC=0x8000_0000, id_ready_i=1, SRAM returns addr^0xA5A5_0000 -> imem_ren_o first high in cycle 1; if_pc_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles from cycle 3, with matching if_inst_o.
- Streaming with id_ready_i low for 3 cycles -> if_* held constant and imem_ren_o=0 during the stall. No PC is skipped or duplicated after id_ready_i returns high.
- Redirect to 0x8000_0103 while stalled with a held response -> imem_addr_o=0x8000_0100 that cycle; the stale response is never presented. Next valid if_pc_o=0x8000_0100, then 0x8000_0104.
- Redirect to 0xFFFF_FFFC -> fetches at 0xFFFF_FFFC, then 0x0000_0000.
- Back-to-back redirects on two consecutive cycles -> only the second target and its successors reach decode.
- rst_n_i asserted mid-stream for 1 cycle -> if_valid_o=0 and imem_ren_o=0 immediately; fetch restarts at RESET_PC with the same post-reset timing.

Source files
------------

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: generates fetch PCs, drives the 1-cycle-latency
// instruction SRAM and presents instructions to decode through valid/ready.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_ren_o,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  input  logic        id_ready_i
);

  // state    | meaning
  // ST_IDLE  | held off after reset; no reads issued, redirects ignored
  // ST_RUN   | fetching
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic        r_out_valid;
  logic [31:0] r_out_pc;
  logic [31:0] r_out_inst;

  logic        w_run;
  logic        w_fire;
  logic        w_capture;
  logic        w_redirect;
  logic        w_issue;
  logic [31:0] w_redirect_addr;
  logic [31:0] w_issue_addr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: w_state_nxt = ST_RUN;
      ST_RUN: begin
        w_state_nxt = ST_RUN;
        w_run       = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // A new read must not be issued while the SRAM still holds an uncaptured
  // response, since it would overwrite the held data.
  assign w_redirect_addr = redirect_pc_i & 32'hFFFF_FFFC;
  assign w_fire          = r_out_valid && id_ready_i;
  assign w_capture       = r_inflight && (!r_out_valid || id_ready_i);
  assign w_redirect      = w_run && redirect_valid_i;
  assign w_issue         = w_redirect || (w_run && (!r_inflight || w_capture));
  assign w_issue_addr    = w_redirect ? w_redirect_addr : r_pc;

  assign imem_ren_o  = w_issue;
  assign imem_addr_o = w_issue_addr;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
    end else if (w_issue) begin
      r_pc          <= w_issue_addr + 32'd4;
      r_inflight    <= 1'b1;
      r_inflight_pc <= w_issue_addr;
    end else if (w_capture) begin
      r_inflight    <= 1'b0;
    end
  end

  // A redirect drops both the output entry and any pending response.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_out_valid <= 1'b0;
      r_out_pc    <= 32'h0;
      r_out_inst  <= 32'h0;
    end else if (w_redirect) begin
      r_out_valid <= 1'b0;
    end else if (w_capture) begin
      r_out_valid <= 1'b1;
      r_out_pc    <= r_inflight_pc;
      r_out_inst  <= imem_rdata_i;
    end else if (w_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign if_valid_o = r_out_valid;
  assign if_pc_o    = r_out_pc;
  assign if_inst_o  = r_out_inst;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch with a one-cycle-latency SRAM
// model that returns addr ^ 0xA5A5_0000 and holds data while not enabled.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] XMASK  = 32'hA5A5_0000;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        imem_ren_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        id_ready_i;

  int n_total = 0;
  int n_pass  = 0;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk_i            (clk_i),
    .rst_n_i          (rst_n_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_ren_o       (imem_ren_o),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .if_valid_o       (if_valid_o),
    .if_pc_o          (if_pc_o),
    .if_inst_o        (if_inst_o),
    .id_ready_i       (id_ready_i)
  );

  always #5 clk_i = ~clk_i;

  initial imem_rdata_i = 32'h0;
  always @(posedge clk_i) if (imem_ren_o) imem_rdata_i <= imem_addr_o ^ XMASK;

  // Move to 1 time unit after the next posedge; inputs are driven there and
  // outputs are checked 1 unit later, well away from either edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = 32'h0; id_ready_i = 1'b1;
    repeat (3) tick();
    #1;
    n_total++; if (imem_ren_o !== 1'b0) $display("FAIL rst_ren got %b exp 0", imem_ren_o); else n_pass++;
    n_total++; if (imem_addr_o !== RST_PC) $display("FAIL rst_addr got %h exp %h", imem_addr_o, RST_PC); else n_pass++;
    n_total++; if ({if_valid_o, if_pc_o, if_inst_o} !== 65'h0) $display("FAIL rst_if got %b/%h/%h exp 0/0/0", if_valid_o, if_pc_o, if_inst_o); else n_pass++;
    rst_n_i = 1'b1;                                    // cycle 0 interval
    #1;
    n_total++; if (imem_ren_o !== 1'b0) $display("FAIL c0_ren got %b exp 0", imem_ren_o); else n_pass++;
    tick(); #1;                                        // cycle 1
    n_total++; if ({imem_ren_o, imem_addr_o} !== {1'b1, RST_PC}) $display("FAIL c1_read got %b/%h exp 1/%h", imem_ren_o, imem_addr_o, RST_PC); else n_pass++;
    tick(); #1;                                        // cycle 2
    n_total++; if ({imem_ren_o, imem_addr_o, if_valid_o} !== {1'b1, 32'h8000_0004, 1'b0}) $display("FAIL c2 got %b/%h/%b exp 1/80000004/0", imem_ren_o, imem_addr_o, if_valid_o); else n_pass++;
    for (int k = 0; k < 3; k++) begin                  // cycles 3,4,5
      logic [31:0] epc;
      tick(); #1;
      epc = RST_PC + 32'(4 * k);
      n_total++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, epc, epc ^ XMASK}) $display("FAIL stream%0d got %b/%h/%h exp 1/%h/%h", k, if_valid_o, if_pc_o, if_inst_o, epc, epc ^ XMASK); else n_pass++;
    end
  endtask

  // Entered showing 0x8000_0008 (undelivered yet); decode stalls 3 cycles.
  task automatic test_stall();
    id_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_total++; if ({imem_ren_o, if_valid_o, if_pc_o, if_inst_o} !== {1'b0, 1'b1, 32'h8000_0008, 32'h25A5_0008}) $display("FAIL stall%0d got ren=%b %b/%h/%h exp ren=0 1/80000008/25a50008", k, imem_ren_o, if_valid_o, if_pc_o, if_inst_o); else n_pass++;
      tick();
    end
    id_ready_i = 1'b1;
    #1;
    n_total++; if ({imem_ren_o, imem_addr_o, if_pc_o} !== {1'b1, 32'h8000_0010, 32'h8000_0008}) $display("FAIL resume got %b/%h pc %h exp 1/80000010 pc 80000008", imem_ren_o, imem_addr_o, if_pc_o); else n_pass++;
    tick(); #1;
    n_total++; if ({if_valid_o, if_pc_o} !== {1'b1, 32'h8000_000C}) $display("FAIL after_stall0 got %b/%h exp 1/8000000c", if_valid_o, if_pc_o); else n_pass++;
    tick(); #1;
    n_total++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h8000_0010, 32'h25A5_0010}) $display("FAIL after_stall1 got %b/%h/%h exp 1/80000010/25a50010", if_valid_o, if_pc_o, if_inst_o); else n_pass++;
  endtask

  // Stall so 0x8000_0014 is held in the SRAM, then redirect to 0x8000_0103.
  task automatic test_redirect_stalled();
    id_ready_i = 1'b0;
    tick();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_0103;
    #1;
    n_total++; if ({imem_ren_o, imem_addr_o} !== {1'b1, 32'h8000_0100}) $display("FAIL redir_addr got %b/%h exp 1/80000100", imem_ren_o, imem_addr_o); else n_pass++;
    tick();
    redirect_valid_i = 1'b0; id_ready_i = 1'b1;
    #1;
    n_total++; if ({if_valid_o, imem_ren_o, imem_addr_o} !== {1'b0, 1'b1, 32'h8000_0104}) $display("FAIL redir_gap got v=%b %b/%h exp v=0 1/80000104", if_valid_o, imem_ren_o, imem_addr_o); else n_pass++;
    tick(); #1;
    n_total++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h8000_0100, 32'h25A5_0100}) $display("FAIL redir_tgt got %b/%h/%h exp 1/80000100/25a50100", if_valid_o, if_pc_o, if_inst_o); else n_pass++;
    tick(); #1;
    n_total++; if ({if_valid_o, if_pc_o} !== {1'b1, 32'h8000_0104}) $display("FAIL redir_next got %b/%h exp 1/80000104", if_valid_o, if_pc_o); else n_pass++;
  endtask

  task automatic test_redirect_wrap();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    #1;
    n_total++; if ({imem_ren_o, imem_addr_o} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_addr got %b/%h exp 1/fffffffc", imem_ren_o, imem_addr_o); else n_pass++;
    tick();
    redirect_valid_i = 1'b0;
    #1;
    n_total++; if ({if_valid_o, imem_ren_o, imem_addr_o} !== {1'b0, 1'b1, 32'h0}) $display("FAIL wrap_next_addr got v=%b %b/%h exp v=0 1/00000000", if_valid_o, imem_ren_o, imem_addr_o); else n_pass++;
    tick(); #1;
    n_total++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC}) $display("FAIL wrap_top got %b/%h/%h exp 1/fffffffc/5a5afffc", if_valid_o, if_pc_o, if_inst_o); else n_pass++;
    tick(); #1;
    n_total++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h0, 32'hA5A5_0000}) $display("FAIL wrap_zero got %b/%h/%h exp 1/00000000/a5a50000", if_valid_o, if_pc_o, if_inst_o); else n_pass++;
  endtask

  task automatic test_back_to_back();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h8000_1000;
    #1;
    n_total++; if (imem_addr_o !== 32'h8000_1000) $display("FAIL b2b_first got %h exp 80001000", imem_addr_o); else n_pass++;
    tick();
    redirect_pc_i = 32'h8000_2000;
    #1;
    n_total++; if ({imem_ren_o, imem_addr_o, if_valid_o} !== {1'b1, 32'h8000_2000, 1'b0}) $display("FAIL b2b_second got %b/%h v=%b exp 1/80002000 v=0", imem_ren_o, imem_addr_o, if_valid_o); else n_pass++;
    tick();
    redirect_valid_i = 1'b0;
    #1;
    n_total++; if (if_valid_o !== 1'b0) $display("FAIL b2b_drop got v=%b pc=%h exp v=0", if_valid_o, if_pc_o); else n_pass++;
    tick(); #1;
    n_total++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h8000_2000, 32'h25A5_2000}) $display("FAIL b2b_tgt got %b/%h/%h exp 1/80002000/25a52000", if_valid_o, if_pc_o, if_inst_o); else n_pass++;
    tick(); #1;
    n_total++; if ({if_valid_o, if_pc_o} !== {1'b1, 32'h8000_2004}) $display("FAIL b2b_next got %b/%h exp 1/80002004", if_valid_o, if_pc_o); else n_pass++;
  endtask

  task automatic test_mid_reset();
    rst_n_i = 1'b0;
    #1;
    n_total++; if ({if_valid_o, imem_ren_o, imem_addr_o, if_pc_o} !== {1'b0, 1'b0, RST_PC, 32'h0}) $display("FAIL mrst_async got v=%b ren=%b addr=%h pc=%h exp 0/0/%h/0", if_valid_o, imem_ren_o, imem_addr_o, if_pc_o, RST_PC); else n_pass++;
    tick();
    rst_n_i = 1'b1;                                    // cycle 0 interval
    #1;
    n_total++; if ({imem_ren_o, if_valid_o} !== 2'b00) $display("FAIL mrst_c0 got ren=%b v=%b exp 0/0", imem_ren_o, if_valid_o); else n_pass++;
    tick(); #1;
    n_total++; if ({imem_ren_o, imem_addr_o} !== {1'b1, RST_PC}) $display("FAIL mrst_c1 got %b/%h exp 1/%h", imem_ren_o, imem_addr_o, RST_PC); else n_pass++;
    tick(); #1;
    n_total++; if ({if_valid_o, imem_addr_o} !== {1'b0, 32'h8000_0004}) $display("FAIL mrst_c2 got v=%b addr=%h exp 0/80000004", if_valid_o, imem_addr_o); else n_pass++;
    tick(); #1;
    n_total++; if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, RST_PC, RST_PC ^ XMASK}) $display("FAIL mrst_c3 got %b/%h/%h exp 1/%h/%h", if_valid_o, if_pc_o, if_inst_o, RST_PC, RST_PC ^ XMASK); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_stalled();
    test_redirect_wrap();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
